// File: rtl/lsu.sv
`default_nettype none
// lsu: handshaked load/store unit with byte-lane steering, load extension and access timeout.
// Rev 1.0
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_cause,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [15:0] cnt_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic [1:0]  cause_q;
   logic [31:0] rdata_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_wdata_q;

   logic        illegal_d;
   logic        misal_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext_d;

   // Request decode uses the live inputs; it is only consumed in IDLE.
   always_comb begin
      illegal_d = req_we ? (funct3 > 3'd2) : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
      misal_d   = (funct3[1:0] == 2'd1 && addr[0]) ||
                  (funct3[1:0] == 2'd2 && addr[1:0] != 2'd0);
      be_d      = 4'b1111;
      wdata_d   = wdata;
      case (funct3[1:0])
         2'd0: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'd1: begin
            be_d    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = wdata;
         end
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'd0:    ext_d = {{24{byte_sel[7]}}, byte_sel};
         3'd1:    ext_d = {{16{half_sel[15]}}, half_sel};
         3'd4:    ext_d = {24'd0, byte_sel};
         3'd5:    ext_d = {16'd0, half_sel};
         default: ext_d = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
         cnt_q       <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cause_q     <= 2'd0;
         rdata_q     <= 32'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'd0;
         mem_wdata_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  we_q   <= req_we;
                  f3_q   <= funct3;
                  off_q  <= addr[1:0];
                  busy_q <= 1'b1;
                  if (illegal_d || misal_d) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     cause_q <= illegal_d ? 2'd2 : 2'd1;
                  end else begin
                     state_q     <= S_REQ;
                     cnt_q       <= 16'd0;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= req_we;
                     mem_addr_q  <= {addr[31:2], 2'b00};
                     mem_be_q    <= be_d;
                     mem_wdata_q <= req_we ? wdata_d : 32'd0;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt || cnt_q >= TO_LAST) begin
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= 32'd0;
                  mem_be_q    <= 4'd0;
                  mem_wdata_q <= 32'd0;
               end
               if (mem_gnt) begin
                  if (we_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else if (mem_rvalid) begin
                     rdata_q <= ext_d;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= cnt_q + 16'd1;
                  end
               end else if (cnt_q >= TO_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  cause_q <= 2'd3;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_WAIT: begin
               // Data arriving on the last allowed cycle still counts as progress.
               if (mem_rvalid) begin
                  rdata_q <= ext_d;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else if (cnt_q >= TO_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  cause_q <= 2'd3;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               cause_q <= 2'd0;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_cause = cause_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// tb_lsu: randomized and directed checks of lsu against a transaction-level timing/data model.
// Rev 1.0
module tb_lsu;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        busy, done, err, mem_req, mem_we;
   logic [1:0]  err_cause;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .err_cause(err_cause),
      .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        exp_busy = 0, exp_done = 0, exp_err = 0, exp_mreq = 0, exp_mwe = 0, exp_wchk = 1;
   logic [1:0]  exp_cause = 0;
   logic [3:0]  exp_mbe = 0;
   logic [31:0] exp_rdata = 0, exp_maddr = 0, exp_mwdata = 0;
   logic [31:0] m_rdata = 0;

   logic        obs_seen, obs_we, obs_err;
   logic [1:0]  obs_cause;
   logic [3:0]  obs_be;
   logic [31:0] obs_addr, obs_wdata, obs_rdata;
   int          obs_done_k;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_err));
      chk("err_cause", 32'(err_cause), 32'(exp_cause));
      chk("rdata", rdata, exp_rdata);
      chk("mem_req", 32'(mem_req), 32'(exp_mreq));
      chk("mem_we", 32'(mem_we), 32'(exp_mwe));
      chk("mem_addr", mem_addr, exp_maddr);
      chk("mem_be", 32'(mem_be), 32'(exp_mbe));
      if (exp_wchk) chk("mem_wdata", mem_wdata, exp_mwdata);
   end

   function automatic bit f_illegal(input bit we, input int f3);
      if (we) return f3 >= 3;
      return f3 == 3 || f3 == 6 || f3 == 7;
   endfunction

   function automatic bit f_misal(input int f3, input logic [31:0] a);
      if ((f3 == 1 || f3 == 5) && a[0]) return 1'b1;
      if (f3 == 2 && a[1:0] != 2'd0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] f_be(input int f3, input int off);
      if (f3 == 0 || f3 == 4) return 4'(1 << off);
      if (f3 == 1 || f3 == 5) return (off >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] f_wdata(input int f3, input logic [31:0] wd);
      if (f3 == 0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      if (f3 == 1) return {wd[15:0], wd[15:0]};
      return wd;
   endfunction

   function automatic logic [31:0] f_ext(input int f3, input int off, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         0:       return b[7] ? (b | 32'hFFFFFF00) : b;
         1:       return h[15] ? (h | 32'hFFFF0000) : h;
         4:       return b;
         5:       return h;
         default: return w;
      endcase
   endfunction

   task automatic set_idle();
      exp_busy = 0; exp_done = 0; exp_err = 0; exp_cause = 0; exp_rdata = m_rdata;
      exp_mreq = 0; exp_mwe = 0; exp_maddr = 0; exp_mbe = 0; exp_mwdata = 0; exp_wchk = 1;
   endtask

   // g: REQ cycles without grant before gnt; r: cycles from gnt to rvalid (0 = same cycle).
   task automatic run(input bit we, input int f3, input logic [31:0] a, input logic [31:0] wd,
                      input int g, input int r, input logic [31:0] rd);
      int done_c, gnt_c, rv_c, n_req, kt;
      bit e, upd;
      logic [1:0]  cause;
      logic [31:0] newd;
      done_c = 0; gnt_c = -1; rv_c = -1; n_req = 0; e = 0; upd = 0; cause = 0; newd = 0;
      if (f_illegal(we, f3) || f_misal(f3, a)) begin
         done_c = 1; e = 1; cause = f_illegal(we, f3) ? 2'd2 : 2'd1;
      end else if (g + 1 > T) begin
         n_req = T; done_c = T + 1; e = 1; cause = 2'd3;
      end else begin
         gnt_c = g + 1; n_req = gnt_c;
         if (we) done_c = gnt_c + 1;
         else begin
            kt = (T > gnt_c + 1) ? T : gnt_c + 1;
            if (r > 0 && kt < gnt_c + r) begin
               done_c = kt + 1; e = 1; cause = 2'd3;
            end else begin
               rv_c = gnt_c + r; done_c = rv_c + 1; upd = 1;
               newd = f_ext(f3, int'(a[1:0]), rd);
            end
         end
      end
      req_valid = 1; req_we = we; funct3 = 3'(f3); addr = a; wdata = wd;
      mem_gnt = 0; mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
      set_idle();
      obs_seen = 0; obs_done_k = -1;
      for (int k = 1; k <= done_c; k++) begin
         @(posedge clk); #1;
         req_valid = 1'($urandom % 2); req_we = 1'($urandom % 2); funct3 = 3'($urandom % 8);
         addr = $urandom; wdata = $urandom;
         mem_gnt = (k == gnt_c);
         mem_rvalid = (k == rv_c) || (k == done_c && ($urandom % 2 == 1));
         mem_rdata = (k == rv_c) ? rd : $urandom;
         exp_busy = 1;
         exp_done = (k == done_c);
         exp_err = exp_done && e;
         exp_cause = exp_done ? cause : 2'd0;
         if (k == done_c && upd) m_rdata = newd;
         exp_rdata = m_rdata;
         exp_mreq = (k <= n_req);
         exp_mwe = exp_mreq && we;
         exp_maddr = exp_mreq ? {a[31:2], 2'b00} : 32'd0;
         exp_mbe = exp_mreq ? f_be(f3, int'(a[1:0])) : 4'd0;
         exp_mwdata = (exp_mreq && we) ? f_wdata(f3, wd) : 32'd0;
         exp_wchk = !exp_mreq || we;
         @(negedge clk);
         if (done) begin
            obs_done_k = k; obs_err = err; obs_cause = err_cause; obs_rdata = rdata;
         end
         if (mem_req && !obs_seen) begin
            obs_seen = 1; obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
         end
      end
      @(posedge clk); #1;
      req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
      set_idle();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      set_idle();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(posedge clk); #1;

      run(1'b1, 0, 32'h1003, 32'hAABBCCDD, 0, 0, 32'h0);
      chk("sb_addr", obs_addr, 32'h1000);
      chk("sb_be", 32'(obs_be), 32'h8);
      chk("sb_wdata", obs_wdata, 32'hDDDDDDDD);
      chk("sb_we", 32'(obs_we), 32'h1);
      chk("sb_done_cycle", 32'(obs_done_k), 32'd2);
      chk("sb_err", 32'(obs_err), 32'h0);

      run(1'b0, 0, 32'h2001, 32'h0, 0, 1, 32'h12348056);
      chk("lb_rdata", obs_rdata, 32'hFFFFFF80);
      chk("lb_done_cycle", 32'(obs_done_k), 32'd3);
      run(1'b0, 4, 32'h2001, 32'h0, 0, 1, 32'h12348056);
      chk("lbu_rdata", obs_rdata, 32'h00000080);
      run(1'b0, 1, 32'h2002, 32'h0, 0, 1, 32'h9ABC0000);
      chk("lh_rdata", obs_rdata, 32'hFFFF9ABC);

      run(1'b0, 2, 32'h3002, 32'h0, 0, 0, 32'h0);
      chk("misal_done_cycle", 32'(obs_done_k), 32'd1);
      chk("misal_cause", 32'(obs_cause), 32'd1);
      chk("misal_noreq", 32'(obs_seen), 32'd0);
      chk("misal_rdata_held", obs_rdata, 32'hFFFF9ABC);
      run(1'b0, 3, 32'h3000, 32'h0, 0, 0, 32'h0);
      chk("illegal_cause", 32'(obs_cause), 32'd2);

      run(1'b0, 2, 32'h3000, 32'h0, 10, 0, 32'h0);
      chk("timeout_cause", 32'(obs_cause), 32'd3);
      chk("timeout_done_cycle", 32'(obs_done_k), 32'd5);

      run(1'b0, 2, 32'h3004, 32'h0, 0, 0, 32'hCAFEF00D);
      chk("lw_fast_rdata", obs_rdata, 32'hCAFEF00D);
      chk("lw_fast_done_cycle", 32'(obs_done_k), 32'd2);

      // Reset in the middle of a load's data wait, followed by a stale rvalid.
      req_valid = 1; req_we = 0; funct3 = 3'd2; addr = 32'h4000; mem_gnt = 0; mem_rvalid = 0;
      @(posedge clk); #1;
      req_valid = 0; mem_gnt = 1;
      exp_busy = 1; exp_mreq = 1; exp_mwe = 0; exp_maddr = 32'h4000; exp_mbe = 4'hF; exp_wchk = 0;
      @(posedge clk); #1;
      mem_gnt = 0;
      exp_mreq = 0; exp_maddr = 0; exp_mbe = 0; exp_mwdata = 0; exp_wchk = 1;
      @(negedge clk); #1;
      rst = 1; m_rdata = 0; set_idle();
      #1;
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      rst = 0; mem_rvalid = 1; mem_rdata = 32'h5555AAAA;
      @(posedge clk); #1;
      mem_rvalid = 0;
      repeat (3) @(posedge clk);
      #1;
      run(1'b1, 2, 32'h5000, 32'h01234567, 1, 0, 32'h0);
      chk("sw_after_rst_be", 32'(obs_be), 32'hF);
      chk("sw_after_rst_done_cycle", 32'(obs_done_k), 32'd3);

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         if ($urandom % 2 == 1) a[1:0] = 2'b00;
         run(1'($urandom % 2), int'($urandom % 8), a, $urandom,
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), $urandom);
      end

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
